// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and helpers for the I2S transmitter
// to_signed() backs the I2S_UNSIGNED_IN_EN input conversion.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_BITS   = 2 * SAMPLE_W_DEF;
  localparam int SAMPLE_W_MAX = 32;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_frame_t;

  // Offset-binary to two's complement: flip the sign bit of a w-bit sample.
  function automatic logic [SAMPLE_W_MAX-1:0] to_signed(input logic [SAMPLE_W_MAX-1:0] s,
                                                         input int unsigned w);
    return s ^ (SAMPLE_W_MAX'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S master timing: BCK divider, falling-event strobe, bit counter, LRCK
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BCK_DIV  = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic bck,
  output logic lrck,
  output logic fall,
  output logic load
);

  localparam int FB    = 2 * SAMPLE_W;
  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int F_W   = $clog2(FB);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bck_q, bck_d;
  logic [F_W-1:0]   f_q, f_d;
  logic             lrck_q, lrck_d;
  logic             tc;

  always_comb begin
    tc     = (div_q == DIV_W'(BCK_DIV - 1));
    div_d  = tc ? '0 : div_q + 1'b1;
    bck_d  = tc ? ~bck_q : bck_q;
    fall   = tc && bck_q;
    load   = fall && (f_q == F_W'(FB - 1));
    f_d    = f_q;
    lrck_d = lrck_q;
    if (fall) begin
      f_d    = load ? '0 : f_q + 1'b1;
      lrck_d = (f_d >= F_W'(SAMPLE_W));
    end
  end

  // f resets to the last slot so the first falling event is a frame load.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bck_q  <= 1'b0;
      f_q    <= F_W'(FB - 1);
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bck_q  <= bck_d;
      f_q    <= f_d;
      lrck_q <= lrck_d;
    end
  end

  assign bck  = bck_q;
  assign lrck = lrck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - stereo PCM to I2S serialiser with one-entry holding buffer
// Define I2S_UNSIGNED_IN_EN to accept offset-binary samples.
module i2s_audio_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BCK_DIV  = 8
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FB = 2 * SAMPLE_W;

  logic fall, load;

  i2s_clkgen #(
    .SAMPLE_W(SAMPLE_W),
    .BCK_DIV (BCK_DIV)
  ) u_clkgen (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bck    (i2s_bck),
    .lrck   (i2s_lrck),
    .fall   (fall),
    .load   (load)
  );

  logic [SAMPLE_W-1:0] cap_left, cap_right;

`ifdef I2S_UNSIGNED_IN_EN
  assign cap_left  = SAMPLE_W'(to_signed(SAMPLE_W_MAX'(in_left), SAMPLE_W));
  assign cap_right = SAMPLE_W'(to_signed(SAMPLE_W_MAX'(in_right), SAMPLE_W));
`else
  assign cap_left  = in_left;
  assign cap_right = in_right;
`endif

  logic [FB-1:0] buf_q, buf_d;
  logic [FB-1:0] last_q, last_d;
  logic [FB-1:0] shift_q, shift_d;
  logic          full_q, full_d;
  logic          ready_q, ready_d;
  logic          data_q, data_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;
  logic          accept;

  always_comb begin
    accept  = in_valid && ready_q;
    buf_d   = buf_q;
    last_d  = last_q;
    shift_d = shift_q;
    full_d  = full_q;
    data_d  = data_q;
    fs_d    = load;
    uf_d    = load && !full_q;
    // The bit left at the top of the shifter is the previous frame's LSB.
    if (fall) begin
      data_d  = shift_q[FB-1];
      shift_d = {shift_q[FB-2:0], 1'b0};
    end
    if (load) begin
      if (full_q) begin
        shift_d = buf_q;
        last_d  = buf_q;
        full_d  = 1'b0;
      end else begin
        shift_d = last_q;
      end
    end
    // accept only happens with full_q low, so it never collides with a buffer drain.
    if (accept) begin
      buf_d  = {cap_left, cap_right};
      full_d = 1'b1;
    end
    ready_d = ~full_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign in_ready    = ready_q;
  assign i2s_data    = data_q;
  assign frame_start = fs_q;
  assign underrun    = uf_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - scoreboard bench for i2s_audio_tx (BCK_DIV=2, SAMPLE_W=16)
module tb_i2s_audio_tx;
  import i2s_pkg::*;

  localparam int SW     = 16;
  localparam int BD     = 2;
  localparam int FR_CYC = 2 * SW * 2 * BD;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [SW-1:0] in_left, in_right;
  logic          in_valid;
  logic          in_ready, i2s_bck, i2s_lrck, i2s_data, frame_start, underrun;

  i2s_audio_tx #(.SAMPLE_W(SW), .BCK_DIV(BD)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .i2s_bck    (i2s_bck),
    .i2s_lrck   (i2s_lrck),
    .i2s_data   (i2s_data),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct packed {
    stereo_frame_t fr;
    logic          uf;
  } req_t;

  req_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [SW-1:0] cv(input logic [SW-1:0] x);
`ifdef I2S_UNSIGNED_IN_EN
    return x ^ 16'h8000;
`else
    return x;
`endif
  endfunction

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic uf);
    req_t e;
    e.fr.left  = l;
    e.fr.right = r;
    e.uf       = uf;
    sb.push_back(e);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!frame_start && n < 1000);
    if (n >= 1000) check("fs_timeout", 1, 0);
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r, output int t);
    int n;
    n        = 0;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 1000) check("send_timeout", 1, 0);
    t = cyc;
    @(negedge clk_sys);
    in_valid = 1'b0;
    check("ready_drop", in_ready, 0);
  endtask

  task automatic wait_bck(input logic v);
    int n;
    n = 0;
    while (i2s_bck !== v && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 100) check("bck_timeout", 1, 0);
  endtask

  // Monitor: pops one entry per frame_start, rebuilds the frame from bits sampled at BCK rise.
  logic [31:0]   cur;
  stereo_frame_t pend_fr, new_fr;
  logic          have_pend = 1'b0, collecting = 1'b0, lrck_bad = 1'b0, prev_bck = 1'b0;
  int            k = 0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      have_pend  = 1'b0;
      collecting = 1'b0;
      lrck_bad   = 1'b0;
      prev_bck   = 1'b0;
      k          = 0;
    end else begin
      if (underrun && !frame_start) check("uf_without_fs", 1, 0);
      if (frame_start) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
          new_fr = '0;
        end else begin
          req_t e;
          e = sb.pop_front();
          check("underrun", underrun, e.uf);
          new_fr = e.fr;
        end
        k          = 0;
        collecting = 1'b1;
      end
      if (i2s_bck && !prev_bck && collecting && k < 32) begin
        if (k == 0) begin
          if (have_pend) begin
            cur[0] = i2s_data;
            check("frame_data", cur, pend_fr);
            check("lrck_pattern", lrck_bad, 0);
          end
          pend_fr   = new_fr;
          have_pend = 1'b1;
          lrck_bad  = 1'b0;
        end else begin
          cur[32-k] = i2s_data;
        end
        if (i2s_lrck !== (k >= SW)) lrck_bad = 1'b1;
        k++;
      end
      prev_bck = i2s_bck;
    end
  end

  initial begin
    int n, c1, c2, t, b1, b2;
    int tc[5];
    stereo_frame_t bp[5];

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    push(16'h0, 16'h0, 1'b1);
    push(16'h0, 16'h0, 1'b1);
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {i2s_bck, i2s_lrck, i2s_data, in_ready, frame_start, underrun}, 6'b000100);

    // Idle after reset: timing and underrun every frame.
    @(negedge clk_sys);
    reset_n = 1'b1;
    wait_fs(n);
    check("first_load_latency", n, 2 * BD);
    c1 = cyc;
    wait_bck(1'b0);
    wait_bck(1'b1);
    b1 = cyc;
    wait_bck(1'b0);
    wait_bck(1'b1);
    b2 = cyc;
    check("bck_period", b2 - b1, 2 * BD);
    wait_fs(n);
    c2 = cyc;
    check("frame_period", c2 - c1, FR_CYC);

    // Single frame.
    push(cv(16'h8001), cv(16'h7FFE), 1'b0);
    send(16'h8001, 16'h7FFE, t);
    wait_fs(n);

    // Underrun hold repeats the last frame.
    push(cv(16'h1234), cv(16'hABCD), 1'b0);
    push(cv(16'h1234), cv(16'hABCD), 1'b1);
    push(cv(16'h1234), cv(16'hABCD), 1'b1);
    send(16'h1234, 16'hABCD, t);
    repeat (3) wait_fs(n);

    // Back-pressure: continuous source, one frame per frame period.
    for (int i = 1; i <= 4; i++) begin
      bp[i].left  = 16'h1111 * i[15:0];
      bp[i].right = ~(16'h0101 * i[15:0]);
      push(cv(bp[i].left), cv(bp[i].right), 1'b0);
    end
    for (int i = 1; i <= 4; i++) send(bp[i].left, bp[i].right, tc[i]);
    check("accept_spacing_3", tc[3] - tc[2], FR_CYC);
    check("accept_spacing_4", tc[4] - tc[3], FR_CYC);
    wait_fs(n);

    // Coincident accept and load with buffer empty.
    push(cv(bp[4].left), cv(bp[4].right), 1'b1);
    push(cv(16'hCAFE), cv(16'hBEEF), 1'b0);
    repeat (FR_CYC - 1) @(negedge clk_sys);
    in_left  = 16'hCAFE;
    in_right = 16'hBEEF;
    in_valid = 1'b1;
    @(negedge clk_sys);
    in_valid = 1'b0;
    check("coincident_fs_uf_ready", {frame_start, underrun, in_ready}, 3'b110);
    repeat (FR_CYC / 2) @(negedge clk_sys);
    check("coincident_ready_mid", in_ready, 0);
    wait_fs(n);
    check("coincident_ready_after", in_ready, 1);
    push(cv(16'hCAFE), cv(16'hBEEF), 1'b1);
    wait_fs(n);

    // Reset mid-frame with a pending buffered frame.
    send(16'h5555, 16'hAAAA, t);
    repeat (39) @(negedge clk_sys);
    @(posedge clk_sys);
    #1 reset_n = 1'b0;
    #1 check("midframe_reset_outputs",
             {i2s_bck, i2s_lrck, i2s_data, in_ready, frame_start, underrun}, 6'b000100);
    push(16'h0, 16'h0, 1'b1);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    wait_fs(n);
    check("reload_latency", n, 2 * BD);
    push(cv(16'hFFFF), cv(16'h0000), 1'b0);
    push(cv(16'hFFFF), cv(16'h0000), 1'b1);
    send(16'hFFFF, 16'h0000, t);
    repeat (2) wait_fs(n);
    repeat (8) @(negedge clk_sys);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Serialises the stereo PCM produced by the Oric guest audio mixer onto the board I2S pins (I2S_BCK, I2S_LRCK, I2S_DATA).
- Sits directly downstream of the guest audio path, in parallel with the sigma-delta AUDIO_L/R outputs.
- Accepts one stereo frame at a time through a valid/ready handshake into a one-entry holding buffer.
- Generates BCK/LRCK as the I2S master from clk_sys.

Parameters:
- SAMPLE_W, 16: bits per channel sample and per I2S channel slot. Frame = 2*SAMPLE_W BCK periods.
- BCK_DIV, 8: clk_sys cycles per BCK half-period. Must be >= 2. BCK period = 2*BCK_DIV clk_sys cycles.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_left  in  SAMPLE_W  left sample
- in_right  in  SAMPLE_W  right sample
- in_valid  in  1  frame offered
- in_ready  out  1  holding buffer empty; can accept
- i2s_bck  out  1  bit clock
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_data  out  1  serial data, MSB first
- frame_start  out  1  one-cycle pulse when a frame is loaded into the shifter
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty

Behaviour:
- Clock and reset: one clock (clk_sys). Reset is asynchronous, active-low (reset_n). All state is clocked on the rising edge of clk_sys.
- Reset values: i2s_bck=0, i2s_lrck=0, i2s_data=0, in_ready=1, frame_start=0, underrun=0. Holding buffer is empty; last-frame register is 0; bit counter f = 2*SAMPLE_W-1.
- Divider: counter runs 0..BCK_DIV-1. On terminal count it wraps to 0 and i2s_bck toggles. A toggle 1->0 is a "falling event"; all data, LRCK and counter updates happen only in the same clk_sys cycle as a falling event.
- Bit counter f (range 0..2*SAMPLE_W-1):
  - Increments on each falling event and wraps to 0.
  - i2s_lrck = (f >= SAMPLE_W), registered with the update.
- I2S alignment:
  - The frame bit stream is {L,R}, MSB first.
  - At f=k, i2s_data carries frame bit k-1.
  - At f=0, i2s_data carries the last bit (LSB of R) of the previous frame.
  - Net effect: the MSB lags the LRCK edge by one BCK, per standard I2S.
- Frame load (the falling event where f wraps to 0):
  - If the buffer is full: the shifter loads the buffer, the buffer is cleared (in_ready=1 from the next cycle), last-frame is updated, and frame_start pulses.
  - If the buffer is empty: the shifter reloads last-frame (hold last value), and frame_start and underrun both pulse.
- Handshake:
  - A transfer occurs when in_valid && in_ready.
  - Data is captured in that cycle; in_ready drops the next cycle.
  - in_ready is a registered, non-combinational function of buffer state.
  - A load event and an accept can coincide only when the buffer is empty. In that case the load takes the underrun path, and the accepted frame stays in the buffer for the next frame.
  - in_valid while in_ready=0 has no effect; the source must hold it.
- Reset mid-frame: all outputs go to their reset values immediately. Any pending buffer is discarded. After reset release, the first falling event produces f=0, i.e. a frame load.

Optional Feature:
- Macro I2S_UNSIGNED_IN_EN.
- When defined: in_left/in_right are offset-binary (the Oric PSG/DAC native format). The MSB of each sample is inverted at capture into the holding buffer, converting it to two's complement. Reset-value last-frame is 0, i.e. midscale after conversion.
- When undefined: samples are two's complement and are passed unchanged.

Decomposition:
- Package i2s_pkg holds:
  - localparam FRAME_BITS = 2*SAMPLE_W default
  - typedef stereo_frame_t, a packed struct {left, right}
  - function to_signed() used by the optional feature.
- One sub-module: i2s_clkgen (divider, bck, falling-event strobe, f counter, lrck). i2s_audio_tx owns the buffer, shifter and handshake.

Test Plan:
- Reset/idle: reset_n low then high, no input, BCK_DIV=2. Expect bck period 4 clk_sys cycles, lrck period 128 clk_sys cycles, i2s_data=0, and an underrun pulse every frame.
- Single frame: send L=16'h8001, R=16'h7FFE before the first load. Expect data bits one BCK after the lrck fall to be 1,0..0,1, then after the lrck rise 0,1..1,0. Expect one frame_start pulse and no underrun on that frame.
- Back-pressure: hold in_valid high continuously with incrementing frames. Expect in_ready to pulse once per frame (every 2*SAMPLE_W BCKs), no underrun, and every frame transmitted exactly once, in order.
- Underrun hold: send one frame L=16'h1234, R=16'hABCD, then stop. Expect the next frames to repeat 1234/ABCD with an underrun pulse each.
- Coincident accept/load: assert in_valid in the exact cycle of a load with the buffer empty. Expect underrun=1, the frame transmitted on the following frame, and in_ready=0 for one frame.
- Reset mid-frame: assert reset_n low at f=10. Expect outputs zero asynchronously and the buffer empty. With I2S_UNSIGNED_IN_EN defined, input 16'hFFFF is transmitted as 16'h7FFF.
